// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter
//   Iterative AES InvSubBytes stage between inv_shift_rows and AddRoundKey.
//   Accepts one 128-bit state over valid/ready, substitutes LANES bytes per
//   clock through LANES inverse S-box tables (MSB byte first), then presents
//   the result over valid/ready.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   data_in carries a valid state
//   in_ready   block can accept a state this cycle
//   data_in    input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  data_out holds a completed result
//   out_ready  downstream accepts data_out this cycle
//   data_out   substituted state, same byte ordering as data_in
//   busy       high while substitution is in progress
module inv_sub_bytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int unsigned CHUNKS = 16 / LANES;
    localparam int unsigned IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(CHUNKS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_next;
    logic [127:0]    st, st_next;
    logic [IDXW-1:0] idx;
    // Holds in_ready low during reset and for the first cycle after release.
    logic            ready_en;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
        endcase
        return r;
    endfunction

    // Working state with the current chunk substituted; the loop body is the
    // LANES S-box instances, each muxing one byte of the chunk.
    always_comb begin
        int unsigned base;
        base    = 32'(idx) * LANES;
        st_next = st;
        for (int unsigned l = 0; l < LANES; l++) begin
            st_next[8*(15 - (base + l)) +: 8] = inv_sbox(st[8*(15 - (base + l)) +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid && ready_en) state_next = S_RUN;
            S_RUN:   if (idx == IDX_LAST) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = in_valid ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: in_ready = ready_en;
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // data_in is only sampled on an accepted handshake, so an unknown bus
    // while in_valid is low never reaches the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            st       <= '0;
            idx      <= '0;
            data_out <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_valid && in_ready) begin
                st  <= data_in;
                idx <= '0;
            end else if (state == S_RUN) begin
                st <= st_next;
                if (idx == IDX_LAST) begin
                    data_out <= st_next;
                    idx      <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter
//   Runs three instances (LANES = 1, 4, 16) side by side. The reference
//   inverse S-box is derived from GF(2^8) arithmetic (forward S-box, then
//   inverted), and a per-instance scoreboard predicts every output each cycle.
module tb_inv_sub_bytes_iter;

    typedef struct {
        logic [127:0] d;
        int unsigned  rdy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   inv_tbl [256];
    logic [127:0] vec     [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_table();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = inv_tbl[d[8*(15-i) +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned L  = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        localparam int unsigned CH = 16 / L;

        logic         rst_n     = 1'b0;
        logic         in_valid  = 1'b0;
        logic         out_ready = 1'b1;
        logic [127:0] data_in   = '0;
        logic         in_ready, out_valid, busy;
        logic [127:0] data_out;
        bit           done      = 1'b0;
        int unsigned  out_cnt   = 0;

        inv_sub_bytes_iter #(.LANES(L)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .data_in   (data_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .data_out  (data_out),
            .busy      (busy)
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d_%s", L, s);
        endfunction

        exp_t         q[$];
        int unsigned  cyc       = 0;
        bit           prev_rst  = 1'b0;
        bit           pend_acc  = 1'b0;
        bit           pend_pop  = 1'b0;
        logic [127:0] pend_data = '0;
        logic [127:0] last_res  = '0;

        // Handshakes seen at one falling edge take effect at the following
        // rising edge and are applied to the model at the next falling edge.
        always @(negedge clk) begin
            bit v_exp, b_exp, r_exp, rdy;
            v_exp = 1'b0; b_exp = 1'b0; r_exp = 1'b0;
            cyc++;
            if (!rst_n) begin
                q.delete();
                last_res = '0;
                prev_rst = 1'b0;
                pend_acc = 1'b0;
                pend_pop = 1'b0;
            end else begin
                if (pend_pop && q.size() > 0) void'(q.pop_front());
                if (pend_acc) q.push_back('{d: model(pend_data), rdy: cyc + CH});
                rdy      = prev_rst;
                prev_rst = 1'b1;
                v_exp    = (q.size() > 0) && (cyc >= q[0].rdy);
                if (v_exp) last_res = q[0].d;
                b_exp    = (q.size() > 0) && !v_exp;
                r_exp    = rdy && ((q.size() == 0) || (v_exp && out_ready));
                pend_acc = in_valid && r_exp;
                pend_pop = v_exp && out_ready;
                pend_data = data_in;
            end
            chk(nm("cyc_out_valid"), 128'(out_valid), 128'(v_exp));
            chk(nm("cyc_busy"), 128'(busy), 128'(b_exp));
            chk(nm("cyc_in_ready"), 128'(in_ready), 128'(r_exp));
            chk(nm("cyc_data_out"), data_out, last_res);
            if (out_valid && out_ready) out_cnt++;
        end

        task automatic send(input logic [127:0] d);
            bit ok = 1'b0;
            in_valid = 1'b1;
            data_in  = d;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            data_in  = rnd();
            if (!ok) chk(nm("accept_timeout"), 128'(0), 128'(1));
        endtask

        task automatic wait_valid(output int lat);
            int n = 0;
            lat = -1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                n++;
                if (out_valid) begin
                    lat = n - 1;
                    break;
                end
            end
            if (lat < 0) chk(nm("valid_timeout"), 128'(0), 128'(1));
        endtask

        task automatic send_check(input logic [127:0] d, input logic [127:0] exp, input string tag);
            int lat;
            send(d);
            wait_valid(lat);
            chk(nm({tag, "_latency"}), 128'(lat), 128'(CH));
            chk(nm({tag, "_data"}), data_out, exp);
            @(posedge clk); #1;
        endtask

        initial begin
            int lat;
            int unsigned cnt0;
            int fed;
            bit acc;
            logic [127:0] held;

            data_in = rnd();
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;

            // reset during the second RUN cycle (only RUN cycle when L=16)
            send(vec[2]);
            if (CH > 1) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b1;
            @(negedge clk);
            chk(nm("rst_out_valid"), 128'(out_valid), 128'(0));
            chk(nm("rst_data_out"), data_out, '0);
            @(negedge clk);
            chk(nm("rst_in_ready"), 128'(in_ready), 128'(1));
            @(posedge clk); #1;

            send_check(128'h7a9f102789d5f50b2beffd9f3dca4ea7,
                       128'hbd6e7c3df2b5779e0b61216e8b10b689, "fips");
            send_check({16{8'h63}}, '0, "all63");
            send_check({16{8'h00}}, {16{8'h52}}, "all00");
            send_check({16{8'hff}}, {16{8'h7d}}, "allff");

            // backpressure
            out_ready = 1'b0;
            send(vec[0]);
            wait_valid(lat);
            chk(nm("bp_latency"), 128'(lat), 128'(CH));
            held = data_out;
            chk(nm("bp_data"), held, model(vec[0]));
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk(nm("bp_hold_data"), data_out, held);
                chk(nm("bp_hold_in_ready"), 128'(in_ready), 128'(0));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            send(vec[1]);
            wait_valid(lat);
            chk(nm("bp_next_latency"), 128'(lat), 128'(CH));
            chk(nm("bp_next_data"), data_out, model(vec[1]));
            @(posedge clk); #1;

            // back-to-back stream, in_valid held high throughout
            cnt0 = out_cnt;
            fed = 0;
            in_valid = 1'b1;
            data_in = vec[0];
            for (int c = 0; c < 600 && fed < 8; c++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                if (acc) begin
                    fed++;
                    if (fed < 8) data_in = vec[fed];
                end
            end
            in_valid = 1'b0;
            data_in = rnd();
            if (fed < 8) chk(nm("stream_feed_timeout"), 128'(fed), 128'(8));
            for (int c = 0; c < 100 && (out_cnt - cnt0) < 8; c++) @(posedge clk);
            repeat (2 * CH + 4) @(posedge clk);
            chk(nm("stream_count"), 128'(out_cnt - cnt0), 128'(8));
            done = 1'b1;
        end
    end

    initial begin
        vec[0] = 128'h00112233445566778899aabbccddeeff;
        vec[1] = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
        vec[2] = 128'h0123456789abcdeffedcba9876543210;
        vec[3] = 128'hdeadbeefcafef00d0badc0de12345678;
        vec[4] = 128'h637c777bf26b6fc53001672bfed7ab76;
        vec[5] = 128'h52096ad53036a538bf40a39e81f3d7fb;
        vec[6] = 128'hffffffff00000000a5a5a5a55a5a5a5a;
        vec[7] = 128'h8e9ff1c64ddce1c7a158d1c8bc9dc1c9;
        build_table();
        chk("model_fips", model(128'h7a9f102789d5f50b2beffd9f3dca4ea7),
            128'hbd6e7c3df2b5779e0b61216e8b10b689);
        chk("model_all63", model({16{8'h63}}), '0);
        chk("model_all00", model('0), {16{8'h52}});
        chk("model_allff", model('1), {16{8'h7d}});
        for (int i = 0; i < 20000 && !(g_inst[0].done && g_inst[1].done && g_inst[2].done); i++)
            @(posedge clk);
        if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done))
            chk("run_timeout", 128'(0), 128'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
